// File: rtl/cheri_dmem_pkg.sv
// Shared types and constants for the tagged data-memory responder.
//   dmem_rsp_t   : one response payload {err, rdata[32:0]} (rdata[32] is the tag)
//   LFSR_SEED    : reset value of the optional grant-stall LFSR
//   DMEM_TAG_BIT : bit position of the capability tag in a 33-bit word
package cheri_dmem_pkg;

    localparam logic [15:0] LFSR_SEED    = 16'hACE1;
    localparam int          DMEM_TAG_BIT = 32;

    typedef struct packed {
        logic        err;
        logic [32:0] rdata;
    } dmem_rsp_t;

endpackage

// File: rtl/cheri_dmem_responder_if.sv
// Data-memory bus between the core (master) and the tagged SRAM responder (slave).
//   data_req / data_gnt       : request handshake (request accepted when both high)
//   data_is_cap, data_we      : capability access flag, write(1)/read(0)
//   data_be, data_addr        : byte enables, byte address (bits [1:0] ignored)
//   data_wdata                : 33-bit write data, bit 32 is the tag
//   data_rvalid, data_rdata   : in-order response, 33-bit read data
//   data_err                  : bus error, qualified by data_rvalid
interface cheri_dmem_responder_if;

    logic        data_req;
    logic        data_is_cap;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [32:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [32:0] data_rdata;
    logic        data_err;

    modport master (
        output data_req, data_is_cap, data_we, data_be, data_addr, data_wdata,
        input  data_gnt, data_rvalid, data_rdata, data_err
    );

    modport slave (
        input  data_req, data_is_cap, data_we, data_be, data_addr, data_wdata,
        output data_gnt, data_rvalid, data_rdata, data_err
    );

endinterface

// File: rtl/cheri_dmem_rsp_pipe.sv
// Fixed-latency response pipe: a Latency-deep shift register of {valid, payload}.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   valid_i      : load a response into stage 0 this edge
//   rsp_i        : response payload for stage 0
//   valid_o      : final-stage valid
//   rsp_o        : final-stage payload, all-zero whenever valid_o is low
module cheri_dmem_rsp_pipe
    import cheri_dmem_pkg::*;
#(
    parameter int Latency = 1
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      valid_i,
    input  dmem_rsp_t rsp_i,
    output logic      valid_o,
    output dmem_rsp_t rsp_o
);

    genvar gi;
    generate
        for (gi = 0; gi < Latency; gi++) begin : g_stage
            logic      valid_q;
            dmem_rsp_t rsp_q;
            logic      valid_d;
            dmem_rsp_t rsp_d;

            if (gi == 0) begin : g_head
                // Payload is zeroed on bubbles so the output needs no masking.
                assign valid_d = valid_i;
                assign rsp_d   = valid_i ? rsp_i : '0;
            end else begin : g_body
                assign valid_d = g_stage[gi-1].valid_q;
                assign rsp_d   = g_stage[gi-1].rsp_q;
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    valid_q <= 1'b0;
                    rsp_q   <= '0;
                end else begin
                    valid_q <= valid_d;
                    rsp_q   <= rsp_d;
                end
            end
        end
    endgenerate

    assign valid_o = g_stage[Latency-1].valid_q;
    assign rsp_o   = g_stage[Latency-1].rsp_q;

endmodule

// File: rtl/cheri_dmem_responder.sv
// Tagged data SRAM responder for the core's data-memory port.
// Accepts req/gnt requests, performs byte-enabled 33-bit tagged reads/writes
// and returns in-order responses a fixed Latency after the grant edge.
//   clk_i, rst_i : clock, asynchronous active-high reset (clears tags, pipe, counter)
//   bus          : slave side of cheri_dmem_responder_if
// Optional build macro CHERI_DMEM_GNT_STALL_EN adds LFSR-driven random grant stalls.
module cheri_dmem_responder
    import cheri_dmem_pkg::*;
#(
    parameter logic [31:0] AddrBase       = 32'h2000_0000,
    parameter int          MemAddrW       = 14,
    parameter int          Latency        = 1,
    parameter int          MaxOutstanding = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    cheri_dmem_responder_if.slave  bus
);

    localparam int Words = 1 << MemAddrW;
    localparam int OutW  = $clog2(MaxOutstanding + 1);

    logic [3:0][7:0]     mem_q [Words];
    logic [Words-1:0]    tag_q;
    logic [OutW-1:0]     outst_q, outst_d;
    logic [31:0]         offset;
    logic                in_range;
    logic [MemAddrW-1:0] word_idx;
    logic                stall;
    logic                room;
    logic                gnt;
    logic                wr_en;
    logic                rsp_valid;
    dmem_rsp_t           rsp_in;
    dmem_rsp_t           rsp_out;

    // Unsigned wrap makes addresses below the base land far out of range.
    assign offset   = bus.data_addr - AddrBase;
    assign in_range = offset < (32'd1 << (MemAddrW + 2));
    assign word_idx = offset[MemAddrW+1:2];

`ifdef CHERI_DMEM_GNT_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 16,14,13,11.
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_d;
    end

    assign stall = lfsr_q[0] & lfsr_q[1];
`else
    assign stall = 1'b0;
`endif

    // A response retiring this cycle frees its slot for a new grant in the same cycle.
    assign room  = (outst_q < OutW'(MaxOutstanding)) | rsp_valid;
    assign gnt   = bus.data_req & ~rst_i & room & ~stall;
    assign wr_en = gnt & bus.data_we & in_range;

    // Data array: no reset, byte-lane writes at the grant edge.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.data_be[b]) mem_q[word_idx][b] <= bus.data_wdata[8*b +: 8];
            end
        end
    end

    // Tag survives only a full-word capability store; anything else clears it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_q <= '0;
        end else if (wr_en) begin
            tag_q[word_idx] <= bus.data_is_cap & (bus.data_be == 4'hF)
                               & bus.data_wdata[DMEM_TAG_BIT];
        end
    end

    // Stage-0 payload: read data is captured at the grant edge, so a write
    // granted in the previous cycle is already visible.
    always_comb begin
        rsp_in = '0;
        if (gnt) begin
            if (!in_range) begin
                rsp_in.err = 1'b1;
            end else if (!bus.data_we) begin
                rsp_in.rdata = {bus.data_is_cap & tag_q[word_idx], mem_q[word_idx]};
            end
        end
    end

    cheri_dmem_rsp_pipe #(.Latency(Latency)) u_rsp_pipe (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (gnt),
        .rsp_i   (rsp_in),
        .valid_o (rsp_valid),
        .rsp_o   (rsp_out)
    );

    always_comb begin
        outst_d = outst_q;
        case ({gnt, rsp_valid})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) outst_q <= '0;
        else       outst_q <= outst_d;
    end

    assign bus.data_gnt    = gnt;
    assign bus.data_rvalid = rsp_valid;
    assign bus.data_rdata  = rsp_out.rdata;
    assign bus.data_err    = rsp_out.err;

    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        rsp_valid |-> (outst_q != '0));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        outst_q <= OutW'(MaxOutstanding));
    a_req_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (bus.data_req && !bus.data_gnt) |=> bus.data_req);
    a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (bus.data_req && !bus.data_gnt) |=> ($stable(bus.data_addr) && $stable(bus.data_we)
                                             && $stable(bus.data_be) && $stable(bus.data_wdata)));

endmodule

// File: tb/tb_cheri_dmem_responder.sv
module tb_cheri_dmem_responder;
    import cheri_dmem_pkg::*;

    localparam logic [31:0] BASE = 32'h2000_0000;
    localparam int          AW   = 14;
    localparam int          LAT  = 3;
    localparam int          MAXO = 2;
    localparam longint      SIZE = longint'(1) << (AW + 2);

    typedef struct {
        bit        we;
        bit        cap;
        bit [3:0]  be;
        bit [31:0] addr;
        bit [32:0] wdata;
    } req_t;

    typedef struct {
        bit        err;
        bit [32:0] rdata;
        int        due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cheri_dmem_responder_if bus_if ();

    cheri_dmem_responder #(
        .AddrBase(BASE), .MemAddrW(AW), .Latency(LAT), .MaxOutstanding(MAXO)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if.slave)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    exp_t        exp_q[$];
    req_t        stim_q[$];
    bit          gnt_log[$];
    bit [31:0]   mem_m[int];
    bit          tag_m[int];
    logic [32:0] last_rdata;
    logic        last_err;
    int          avail_cnt = 0;
    int          stall_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: a flat word/tag store addressed by byte offset from the base.
    function automatic exp_t model(req_t r, int due);
        exp_t        e;
        longint      a;
        int          w;
        bit [31:0]   word;
        e.err = 1'b0; e.rdata = '0; e.due = due;
        a = longint'(r.addr);
        if (a < longint'(BASE) || a >= longint'(BASE) + SIZE) begin
            e.err = 1'b1;
            return e;
        end
        w = int'((a - longint'(BASE)) / 4);
        if (r.we) begin
            word = mem_m.exists(w) ? mem_m[w] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (r.be[b]) word[8*b +: 8] = r.wdata[8*b +: 8];
            mem_m[w] = word;
            tag_m[w] = r.cap && (r.be == 4'hF) && r.wdata[32];
        end else begin
            e.rdata = {r.cap && tag_m.exists(w) && tag_m[w], mem_m[w]};
        end
        return e;
    endfunction

    // Bus monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin : mon
        int   retiring;
        bit   cap_ok;
        req_t r;
        exp_t e;
        if (rst) begin
            exp_q.delete();
            tag_m.delete();
        end else begin
            retiring = (exp_q.size() > 0 && exp_q[0].due == cyc) ? 1 : 0;
            cap_ok   = (exp_q.size() - retiring) < MAXO;
            if (!bus_if.data_req) begin
                chk("gnt_without_req", 64'(bus_if.data_gnt), 64'd0);
            end else begin
                if (cap_ok) begin
                    avail_cnt++;
                    if (!bus_if.data_gnt) stall_cnt++;
                end
`ifdef CHERI_DMEM_GNT_STALL_EN
                if (bus_if.data_gnt) chk("gnt_room", 64'(cap_ok), 64'd1);
`else
                chk("gnt", 64'(bus_if.data_gnt), 64'(cap_ok));
`endif
            end
            if (bus_if.data_rvalid) begin
                if (exp_q.size() == 0) begin
                    chk("rvalid_unexpected", 64'(bus_if.data_rvalid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rdata", 64'(bus_if.data_rdata), 64'(e.rdata));
                    chk("err", 64'(bus_if.data_err), 64'(e.err));
                    chk("latency", 64'(cyc), 64'(e.due));
                    last_rdata = bus_if.data_rdata;
                    last_err   = bus_if.data_err;
                end
            end else begin
                chk("rdata_idle", 64'(bus_if.data_rdata), 64'd0);
                chk("err_idle", 64'(bus_if.data_err), 64'd0);
            end
            if (bus_if.data_gnt) begin
                r.we = bus_if.data_we; r.cap = bus_if.data_is_cap; r.be = bus_if.data_be;
                r.addr = bus_if.data_addr; r.wdata = bus_if.data_wdata;
                exp_q.push_back(model(r, cyc + LAT));
                chk("outstanding", 64'(exp_q.size() <= MAXO), 64'd1);
            end
        end
    end

    task automatic push(bit we, bit cap, bit [3:0] be, bit [31:0] addr, bit [32:0] wdata);
        req_t r;
        r.we = we; r.cap = cap; r.be = be; r.addr = addr; r.wdata = wdata;
        stim_q.push_back(r);
    endtask

    // Issues every queued request, holding req high until each is granted.
    task automatic run_stim();
        int wait_cyc = 0;
        bit g;
        while (stim_q.size() > 0) begin
            bus_if.data_req    = 1'b1;
            bus_if.data_we     = stim_q[0].we;
            bus_if.data_is_cap = stim_q[0].cap;
            bus_if.data_be     = stim_q[0].be;
            bus_if.data_addr   = stim_q[0].addr;
            bus_if.data_wdata  = stim_q[0].wdata;
            @(negedge clk);
            g = bus_if.data_gnt;
            gnt_log.push_back(g);
            if (g) begin
                void'(stim_q.pop_front());
                wait_cyc = 0;
            end else begin
                wait_cyc++;
            end
            @(posedge clk); #1;
            if (wait_cyc > 100) begin
                chk("gnt_timeout", 64'(wait_cyc), 64'd0);
                stim_q.delete();
            end
        end
        bus_if.data_req = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && exp_q.size() > 0; k++) begin
            @(posedge clk); #1;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [31:0] pre0;
        bit [7:0]  pat;
        int        k, pct;
        bus_if.data_req = 1'b0; bus_if.data_we = 1'b0; bus_if.data_is_cap = 1'b0;
        bus_if.data_be = 4'h0; bus_if.data_addr = '0; bus_if.data_wdata = '0;

        // Reset state, with req high to prove grant is held off.
        repeat (2) @(posedge clk);
        #1 bus_if.data_req = 1'b1;
        #1;
        chk("rst_gnt", 64'(bus_if.data_gnt), 64'd0);
        chk("rst_rvalid", 64'(bus_if.data_rvalid), 64'd0);
        chk("rst_rdata", 64'(bus_if.data_rdata), 64'd0);
        chk("rst_err", 64'(bus_if.data_err), 64'd0);
        bus_if.data_req = 1'b0;
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;

        // Preload the words used later.
        pre0 = $urandom;
        push(1, 1, 4'hF, BASE, {1'b1, pre0});
        for (int i = 1; i < 16; i++) push(1, 1, 4'hF, BASE + 4 * i, {1'($urandom), 32'($urandom)});
        push(1, 1, 4'hF, BASE + 32'h0000_FFFC, {1'b1, 32'($urandom)});
        run_stim(); drain();

        // Capability store then capability load.
        push(1, 1, 4'hF, 32'h2000_0010, 33'h1_DEAD_BEEF);
        push(0, 1, 4'hF, 32'h2000_0010, 33'h0);
        run_stim(); drain();
        chk("cap_load", 64'(last_rdata), 64'h1_DEAD_BEEF);
        chk("cap_load_err", 64'(last_err), 64'd0);

        // Partial store clears the tag; non-cap read hides the tag.
        push(1, 1, 4'h1, 32'h2000_0010, 33'h0_0000_0055);
        push(0, 1, 4'hF, 32'h2000_0010, 33'h0);
        run_stim(); drain();
        chk("partial_clears_tag", 64'(last_rdata), 64'h0_DEAD_BE55);
        push(1, 1, 4'hF, 32'h2000_0014, 33'h1_CAFE_F00D);
        push(0, 0, 4'hF, 32'h2000_0014, 33'h0);
        run_stim(); drain();
        chk("noncap_read_tag", 64'(last_rdata), 64'h0_CAFE_F00D);

        // Out of range, both sides of the window; writes must not alias.
        push(0, 0, 4'hF, 32'h1FFF_FFFC, 33'h0);
        run_stim(); drain();
        chk("oor_low_err", 64'(last_err), 64'd1);
        chk("oor_low_rdata", 64'(last_rdata), 64'd0);
        push(0, 0, 4'hF, BASE + 32'h0001_0000, 33'h0);
        run_stim(); drain();
        chk("oor_high_err", 64'(last_err), 64'd1);
        chk("oor_high_rdata", 64'(last_rdata), 64'd0);
        push(1, 1, 4'hF, 32'h1FFF_FFFC, 33'h1_1111_1111);
        push(1, 1, 4'hF, BASE + 32'h0001_0000, 33'h1_2222_2222);
        push(0, 0, 4'hF, BASE + 32'h0000_FFFC, 33'h0);
        push(0, 0, 4'hF, BASE, 33'h0);
        run_stim(); drain();
        chk("oor_no_alias", 64'(last_rdata), 64'(pre0));

        // Outstanding limit: six reads with req held high.
        gnt_log.delete();
        for (int i = 0; i < 6; i++) push(0, 1, 4'hF, BASE + 4 * i, 33'h0);
        run_stim(); drain();
`ifndef CHERI_DMEM_GNT_STALL_EN
        pat = 8'b1101_1011;
        chk("gnt_pat_len", 64'(gnt_log.size()), 64'd8);
        for (int i = 0; i < 8 && i < gnt_log.size(); i++)
            chk("gnt_pat", 64'(gnt_log[i]), 64'(pat[7 - i]));
`endif

        // Reset mid-operation.
        push(1, 1, 4'hF, BASE + 32, 33'h1_1234_5678);
        push(1, 1, 4'hF, BASE + 36, 33'h1_8765_4321);
        run_stim();
        k = 0;
        while (!bus_if.data_rvalid && k < 10) begin
            @(posedge clk); #1; k++;
        end
        chk("rvalid_before_rst", 64'(bus_if.data_rvalid), 64'd1);
        #1 rst = 1'b1;
        bus_if.data_req = 1'b1; bus_if.data_we = 1'b0; bus_if.data_addr = BASE + 32;
        #1;
        chk("midrst_gnt", 64'(bus_if.data_gnt), 64'd0);
        chk("midrst_rvalid", 64'(bus_if.data_rvalid), 64'd0);
        chk("midrst_rdata", 64'(bus_if.data_rdata), 64'd0);
        repeat (2) @(posedge clk);
        #1 bus_if.data_req = 1'b0;
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("no_stale_rvalid", 64'(bus_if.data_rvalid), 64'd0);
        end
        push(0, 1, 4'hF, BASE + 32, 33'h0);
        run_stim(); drain();
        chk("tag_cleared_by_rst", 64'(last_rdata), 64'h0_1234_5678);

        // Randomised traffic against the scoreboard.
        avail_cnt = 0; stall_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            bit [31:0] a;
            k = $urandom_range(0, 19);
            if (k < 16)       a = BASE + 4 * k + 32'($urandom_range(0, 3));
            else if (k == 16) a = BASE + 32'h0000_FFFC;
            else if (k == 17) a = BASE - 4 * 32'($urandom_range(1, 8));
            else if (k == 18) a = BASE + 32'h0001_0000 + 4 * 32'($urandom_range(0, 7));
            else              a = $urandom | 32'h8000_0000;
            push(1'($urandom), 1'($urandom), ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom),
                 a, {1'($urandom), 32'($urandom)});
        end
        run_stim(); drain();
`ifdef CHERI_DMEM_GNT_STALL_EN
        pct = (avail_cnt > 0) ? (stall_cnt * 100) / avail_cnt : 0;
        chk("stall_frac_lo", 64'(pct >= 15), 64'd1);
        chk("stall_frac_hi", 64'(pct <= 35), 64'd1);
`else
        pct = 0;
        chk("no_stalls", 64'(stall_cnt), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
